// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the HI/LO pair: pipelined multiplier
// with accumulate/subtract, radix-2 restoring divider, flush and stall handling.
module muldiv_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;

   localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic [WIDTH-1:0]   a_reg, b_reg, rem_reg;
   logic [CW-1:0]      cnt_reg;
   logic               mul_signed_reg;
   logic [1:0]         mul_mode_reg;
   logic               sign_q_reg, sign_r_reg, div_zero_reg;

   logic               is_mul_op, is_div_op, long_op, accept;
   logic               neg_a_in, neg_b_in, srcb_zero, mul_signed_in;
   logic [1:0]         mul_mode_in;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_res, hilo, mul_acc;
   logic [WIDTH:0]     rem_shift, rem_diff;

   // Operand decode for the accept cycle
   always_comb begin
      is_mul_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                      (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
      is_div_op     = (op == OP_DIV) || (op == OP_DIVU);
      long_op       = is_mul_op || is_div_op;
      accept        = (state_reg == S_IDLE) && start && !flush;
      neg_a_in      = (op == OP_DIV) && srca[WIDTH-1];
      neg_b_in      = (op == OP_DIV) && srcb[WIDTH-1];
      srcb_zero     = (srcb == '0);
      abs_a         = neg_a_in ? -srca : srca;
      abs_b         = neg_b_in ? -srcb : srcb;
      mul_signed_in = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
      mul_mode_in   = 2'd0;
      if ((op == OP_MADD) || (op == OP_MADDU)) mul_mode_in = 2'd1;
      if ((op == OP_MSUB) || (op == OP_MSUBU)) mul_mode_in = 2'd2;
   end

   // Full-width product of the latched operands, sign-extended when signed
   always_comb begin
      ext_a   = {{WIDTH{mul_signed_reg & a_reg[WIDTH-1]}}, a_reg};
      ext_b   = {{WIDTH{mul_signed_reg & b_reg[WIDTH-1]}}, b_reg};
      product = ext_a * ext_b;
      hilo    = {hi_reg, lo_reg};
      case (mul_mode_reg)
         2'd1:    mul_acc = hilo + mul_res;
         2'd2:    mul_acc = hilo - mul_res;
         default: mul_acc = mul_res;
      endcase
   end

   generate
      if (MUL_STAGES > 1) begin : g_pipe
         logic [2*WIDTH-1:0] pipe_reg [MUL_STAGES-1];
         always_ff @(posedge clk) begin
            pipe_reg[0] <= product;
            for (int i = MUL_STAGES - 2; i > 0; i--) begin
               pipe_reg[i] <= pipe_reg[i-1];
            end
         end
         assign mul_res = pipe_reg[MUL_STAGES-2];
      end else begin : g_comb
         assign mul_res = product;
      end
   endgenerate

   // Restoring step: a_reg shifts the dividend out and the quotient in
   always_comb begin
      rem_shift = {rem_reg, a_reg[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, b_reg};
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept && is_mul_op)      state_next = S_MUL;
            else if (accept && is_div_op) state_next = S_DIV;
         end
         S_MUL: begin
            if (flush)                      state_next = S_IDLE;
            else if (cnt_reg == MUL_LAST)   state_next = S_DONE;
         end
         S_DIV: begin
            if (flush)                                    state_next = S_IDLE;
            else if (div_zero_reg || cnt_reg == DIV_LAST) state_next = S_FIX;
         end
         S_FIX:   state_next = flush ? S_IDLE : S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_reg         <= '0;
         lo_reg         <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         rem_reg        <= '0;
         cnt_reg        <= '0;
         mul_signed_reg <= 1'b0;
         mul_mode_reg   <= 2'd0;
         sign_q_reg     <= 1'b0;
         sign_r_reg     <= 1'b0;
         div_zero_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  cnt_reg <= '0;
                  if (op == OP_MTHI) hi_reg <= srca;
                  if (op == OP_MTLO) lo_reg <= srca;
                  if (is_mul_op) begin
                     a_reg          <= srca;
                     b_reg          <= srcb;
                     mul_signed_reg <= mul_signed_in;
                     mul_mode_reg   <= mul_mode_in;
                  end
                  if (is_div_op) begin
                     // Divide by zero keeps the raw dividend for HI
                     a_reg        <= srcb_zero ? srca : abs_a;
                     b_reg        <= abs_b;
                     rem_reg      <= '0;
                     sign_q_reg   <= neg_a_in ^ neg_b_in;
                     sign_r_reg   <= neg_a_in;
                     div_zero_reg <= srcb_zero;
                  end
               end
            end
            S_MUL: begin
               if (!flush) begin
                  cnt_reg <= cnt_reg + CW'(1);
                  if (cnt_reg == MUL_LAST) {hi_reg, lo_reg} <= mul_acc;
               end
            end
            S_DIV: begin
               if (!flush && !div_zero_reg) begin
                  cnt_reg <= cnt_reg + CW'(1);
                  if (!rem_diff[WIDTH]) begin
                     rem_reg <= rem_diff[WIDTH-1:0];
                     a_reg   <= {a_reg[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_reg <= rem_shift[WIDTH-1:0];
                     a_reg   <= {a_reg[WIDTH-2:0], 1'b0};
                  end
               end
            end
            S_FIX: begin
               if (!flush) begin
                  if (div_zero_reg) begin
                     hi_reg <= a_reg;
                     lo_reg <= '1;
                  end else begin
                     hi_reg <= sign_r_reg ? -rem_reg : rem_reg;
                     lo_reg <= sign_q_reg ? -a_reg : a_reg;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hi    = hi_reg;
   assign lo    = lo_reg;
   assign busy  = (state_reg != S_IDLE);
   assign done  = (state_reg == S_DONE);
   assign stall = start && long_op && (state_reg != S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model with directed and random ops,
// plus a small directed run on a 16-bit single-stage instance.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [3:0]  op;
   logic [31:0] srca, srcb;
   logic [31:0] hi, lo;
   logic        busy, done, stall;

   logic        start16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, hi16, lo16;
   logic        busy16, done16, stall16;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   muldiv_unit #(.WIDTH(16), .MUL_STAGES(1)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .op(op16), .srca(a16), .srcb(b16),
      .flush(1'b0), .hi(hi16), .lo(lo16), .busy(busy16), .done(done16), .stall(stall16)
   );

   // Reference model: pending op + cycles remaining until HI/LO commit
   bit [31:0] m_hi, m_lo, m_a, m_b;
   bit [3:0]  m_op;
   int        m_rem;
   bit        m_done;

   function automatic bit is_long(input logic [3:0] o);
      return (o >= 4'd1) && (o <= 4'd8);
   endfunction

   function automatic bit [63:0] model_result(input bit [3:0] o, input bit [31:0] a, b,
                                              input bit [31:0] hv, lv);
      bit [63:0] p;
      longint    q, r;
      p = 64'd0;
      if (o == 4'd1 || o == 4'd5 || o == 4'd7) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      if (o == 4'd2 || o == 4'd6 || o == 4'd8) p = {32'd0, a} * {32'd0, b};
      case (o)
         4'd1, 4'd2: return p;
         4'd5, 4'd6: return {hv, lv} + p;
         4'd7, 4'd8: return {hv, lv} - p;
         4'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return {hv, lv};
      endcase
   endfunction

   always @(posedge clk) begin
      cycle++;
      if (rst) begin
         m_hi = 0; m_lo = 0; m_rem = 0; m_done = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_rem > 0) begin
         if (flush) m_rem = 0;
         else begin
            m_rem--;
            if (m_rem == 0) begin
               {m_hi, m_lo} = model_result(m_op, m_a, m_b, m_hi, m_lo);
               m_done = 1;
            end
         end
      end else if (start && !flush) begin
         if (op == 4'd9)  m_hi = srca;
         if (op == 4'd10) m_lo = srca;
         if (is_long(op)) begin
            m_op = op; m_a = srca; m_b = srcb;
            if (op == 4'd3 || op == 4'd4) m_rem = (srcb == 32'd0) ? 2 : 33;
            else m_rem = 2;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(posedge clk) begin
      bit e_busy, e_stall;
      #1;
      e_busy  = (m_rem > 0) || m_done;
      e_stall = start && is_long(op) && !m_done;
      n_tests++;
      if (hi !== m_hi || lo !== m_lo || busy !== e_busy || done !== m_done || stall !== e_stall) begin
         n_fail++;
         $display("FAIL cycle %0d outputs: hi=%h/%h lo=%h/%h busy=%b/%b done=%b/%b stall=%b/%b (got/want)",
                  cycle, hi, m_hi, lo, m_lo, busy, e_busy, done, m_done, stall, e_stall);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit rnd_flush, output int cyc);
      bit flushed;
      flushed = 0;
      op = o; srca = a; srcb = b; start = 1'b1; cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         flush = 1'b0;
         if (!stall) break;
         if (cyc >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL timeout op=%0d: stall still high after %0d cycles", o, cyc);
            break;
         end
         if (rnd_flush && !flushed && $urandom_range(0, 39) == 0) begin
            flush = 1'b1; flushed = 1;
         end
      end
      start = 1'b0; op = 4'd0;
   endtask

   task automatic run_op16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                           output int cyc);
      op16 = o; a16 = a; b16 = b; start16 = 1'b1; cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (!stall16) break;
         if (cyc >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL timeout16 op=%0d: stall still high after %0d cycles", o, cyc);
            break;
         end
      end
      start16 = 1'b0; op16 = 4'd0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int c;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; srca = 0; srcb = 0;
      start16 = 1'b0; op16 = 4'd0; a16 = 0; b16 = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_busy_done", {busy, done}, 2'b00);

      run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 0, c);
      check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      check("mult_done", done, 1'b1);
      check("mult_cycles", c, 3);
      @(negedge clk);
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, c);
      check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      check("div_cycles", c, 34);
      @(negedge clk);
      run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 0, c);
      check("divu_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
      @(negedge clk);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, c);
      check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
      @(negedge clk);
      run_op(4'd4, 32'h1234, 32'd0, 0, c);
      check("divu_zero_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
      check("divu_zero_cycles", c, 3);
      @(negedge clk);
      run_op(4'd9, 32'd1, 32'd0, 0, c);
      run_op(4'd10, 32'hFFFF_FFFF, 32'd0, 0, c);
      check("mthi_mtlo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
      run_op(4'd6, 32'd2, 32'd3, 0, c);
      check("maddu_hilo", {hi, lo}, 64'h0000_0002_0000_0005);
      @(negedge clk);
      run_op(4'd7, 32'd1, 32'd6, 0, c);
      check("msub_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);

      // Flush a divide partway through its iterations
      @(negedge clk);
      op = 4'd3; srca = 32'd100; srcb = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_done", {busy, done}, 2'b00);
      check("flush_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
      repeat (3) @(negedge clk);
      check("flush_no_done", done, 1'b0);

      // Reset in the middle of a multiply
      op = 4'd1; srca = 32'd3; srcb = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 4'd0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_mul", {hi, lo, busy, done}, 66'd0);

      run_op16(4'd1, 16'h8000, 16'h8000, c);
      check("mult16_hilo", {hi16, lo16}, 32'h4000_0000);
      check("mult16_cycles", c, 2);
      @(negedge clk);
      run_op16(4'd3, 16'h8000, 16'h0003, c);
      check("div16_hilo", {hi16, lo16}, 32'hFFFE_D556);
      check("div16_cycles", c, 18);

      for (int i = 0; i < 300; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 7) == 0);
         end
         run_op(4'($urandom_range(0, 15)), pick(), pick(), 1, c);
      end
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide engine that owns the HI/LO register pair for the EX stage.
- It replaces the combinational multiplier and external divider handshake with one unit.
- Adds a pipelined multiplier, a WIDTH-cycle radix-2 divider, multiply-accumulate/subtract, flush and a pipeline stall output.
- The datapath presents an op with start and holds it stable while stall is high.

Parameters:
- WIDTH, 32: operand width; HI/LO are each WIDTH bits.
- MUL_STAGES, 2: multiplier latency in cycles (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  op valid from EX
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11-15 NOP
- srca  in  WIDTH  operand A / dividend / MTHI-MTLO data
- srcb  in  WIDTH  operand B / divisor
- flush  in  1  abort in-flight op (exception/branch flush)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  unit not IDLE
- done  out  1  one-cycle pulse: long op completed, HI/LO updated
- stall  out  1  combinational: start && long op (1-8) && state != DONE

Behaviour:
- Reset (rst=1 at edge): hi=0, lo=0, state IDLE, busy=0, done=0, counters 0. Priority: rst > flush > start.
- Ops are sampled only in IDLE; start in any other state is ignored.
- MTHI/MTLO: in IDLE, hi (or lo) <= srca at next edge; no busy, no done, no stall.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> MUL on start with op 1,2,5-8; operands latched at accept edge k.
- MUL: HI/LO written at edge k+MUL_STAGES, then DONE.
- IDLE -> DIV on start with op 3/4: latch |a|, |b| (signed) or raw (unsigned) plus sign flags. DIV runs WIDTH restoring iterations, one quotient bit per cycle. FIX applies signs and writes HI/LO at edge k+WIDTH+1, then DONE.
- DONE: done=1 and busy=1 for exactly one cycle, stall=0 so the pipeline advances; -> IDLE unconditionally. A start held through DONE is not re-accepted.
- Multiply: full 2*WIDTH product; signed for MULT/MADD/MSUB, unsigned for MULTU/MADDU/MSUBU.
- MULT/MULTU: {hi,lo} <= product.
- MADD*: {hi,lo} <= {hi,lo} + product. MSUB*: {hi,lo} <= {hi,lo} - product. Uses HI/LO as of the write edge, modulo 2^(2*WIDTH), no overflow flag.
- Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Signed most-negative / -1: lo = most-negative (wraps), hi = 0.
- Divide by zero: no iteration. FIX is entered at the cycle after accept; lo = all ones, hi = srca; done follows as usual (total 2 cycles to DONE).
- flush=1 in MUL/DIV/FIX: -> IDLE at that edge, HI/LO unchanged, no done pulse.
- flush in DONE: HI/LO already committed, so it has no effect on HI/LO.
- flush with start in IDLE: op not accepted, including MTHI/MTLO.
- busy=1 in MUL, DIV, FIX and DONE.

Test Plan:
- WIDTH=32, MUL_STAGES=2: MULT srca=FFFFFFFD (-3), srcb=5 accepted at edge k -> hi=FFFFFFFF, lo=FFFFFFF1 after edge k+2; done=1 cycle k+2..k+3; stall high 2 cycles only.
- DIV srca=FFFFFFF9 (-7), srcb=2 -> after edge k+33: lo=FFFFFFFD, hi=FFFFFFFF; done one cycle. DIVU same operands -> lo=7FFFFFFC, hi=1.
- DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0. DIVU 1234 / 0 -> lo=FFFFFFFF, hi=1234, done 2 cycles after accept.
- MTHI 1 and MTLO FFFFFFFF, then MADDU 2*3 -> hi=2, lo=5. Then MSUB 1*6 -> hi=1, lo=FFFFFFFF.
- Start DIV, assert flush at iteration 10 -> back to IDLE next edge, hi/lo unchanged, no done. Assert rst mid-MUL -> all outputs 0 after edge.
- WIDTH=16, MUL_STAGES=1: MULT 8000*8000 -> hi=4000, lo=0000 after 1 cycle. DIV 8000/0003 -> lo=D556, hi=FFFE after 17 cycles.
